// File: rtl/edge_detector_multi.sv
// N-channel debounced edge detector: per-channel synchroniser, edge FSM with
// post-edge lockout, 1-cycle rising/falling pulses and a debounced level.

module edge_ch #(
    parameter int         HOLD_CYCLES = 130000,
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] EDGE_MODE   = 2'b11
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic rising,
    output logic falling,
    output logic level
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'd0,
        LOCK_HIGH = 2'd1,
        HIGH_IDLE = 2'd2,
        LOCK_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   level_nx, rise_nx, fall_nx;

    // The FSM only ever looks at the last synchroniser stage.
    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= '0;
            state   <= LOW_IDLE;
            cnt     <= '0;
            level   <= 1'b0;
            rising  <= 1'b0;
            falling <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], din};
            state   <= state_nx;
            cnt     <= cnt_nx;
            level   <= level_nx;
            rising  <= rise_nx;
            falling <= fall_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            LOW_IDLE: begin
                if (s) begin
                    state_nx = LOCK_HIGH;
                    level_nx = 1'b1;
                    rise_nx  = EDGE_MODE[0] & en;
                    cnt_nx   = '0;
                end
            end
            LOCK_HIGH: begin
                // Input ignored while locked; a pending change is taken in HIGH_IDLE.
                if (cnt == LAST) begin
                    state_nx = HIGH_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HIGH_IDLE: begin
                if (!s) begin
                    state_nx = LOCK_LOW;
                    level_nx = 1'b0;
                    fall_nx  = EDGE_MODE[1] & en;
                    cnt_nx   = '0;
                end
            end
            LOCK_LOW: begin
                if (cnt == LAST) begin
                    state_nx = LOW_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = LOW_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
endmodule

module edge_detector_multi #(
    parameter int         N_CH        = 4,
    parameter int         HOLD_CYCLES = 130000,
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] EDGE_MODE   = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    input  logic            en,
    output logic [N_CH-1:0] rising,
    output logic [N_CH-1:0] falling,
    output logic [N_CH-1:0] level,
    output logic            any_edge
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_ch #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE_MODE  (EDGE_MODE)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .din    (din[i]),
            .en     (en),
            .rising (rising[i]),
            .falling(falling[i]),
            .level  (level[i])
        );
    end

    // Combinational so it lands in the same cycle as the registered pulses.
    assign any_edge = |(rising | falling);
endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi (N_CH=4, HOLD_CYCLES=8, SYNC_STAGES=2).

module tb_edge_detector_multi;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       en;
    logic [3:0] rising, falling, level;
    logic       any_edge;

    int nvec = 0;
    int nerr = 0;
    int rc[4];
    int fc[4];

    edge_detector_multi #(
        .N_CH(4), .HOLD_CYCLES(8), .SYNC_STAGES(2), .EDGE_MODE(2'b11)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .en(en),
        .rising(rising), .falling(falling), .level(level), .any_edge(any_edge)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, accumulate pulse counts.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rc[i] += int'(rising[i]);
            fc[i] += int'(falling[i]);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            rc[i] = 0;
            fc[i] = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 4'b0000;
        en  = 1'b1;
        clr();
        run(3);
        chk("rst_rising", 32'(rising), 32'h0);
        chk("rst_falling", 32'(falling), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_any", 32'(any_edge), 32'h0);
        rst = 1'b0;
        run(2);

        // 1: latency of a clean rising edge on ch0
        din = 4'b0001;
        tick();
        chk("t1_e1_rising", 32'(rising), 32'h0);
        tick();
        chk("t1_e2_rising", 32'(rising), 32'h0);
        chk("t1_e2_level", 32'(level), 32'h0);
        tick();
        chk("t1_e3_rising", 32'(rising), 32'h1);
        chk("t1_e3_level", 32'(level), 32'h1);
        chk("t1_e3_any", 32'(any_edge), 32'h1);
        tick();
        chk("t1_e4_rising", 32'(rising), 32'h0);
        chk("t1_e4_any", 32'(any_edge), 32'h0);
        chk("t1_e4_level", 32'(level), 32'h1);
        // release during lockout: falling accepted after exit
        clr();
        din = 4'b0000;
        run(20);
        chk("t1_fall_cnt", 32'(fc[0]), 32'd1);
        chk("t1_rise_cnt", 32'(rc[0]), 32'd0);
        chk("t1_level_low", 32'(level), 32'h0);

        // 2: bounce on ch0
        clr();
        din = 4'b0001; tick();
        din = 4'b0000; tick();
        din = 4'b0001; tick();
        din = 4'b0000; tick();
        din = 4'b0001;
        run(20);
        chk("t2_rise_cnt", 32'(rc[0]), 32'd1);
        chk("t2_fall_cnt", 32'(fc[0]), 32'd0);
        chk("t2_level", 32'(level), 32'h1);
        clr();
        din = 4'b0000;
        run(20);
        chk("t2_release_fall", 32'(fc[0]), 32'd1);

        // 3: ch1 short press, falling 9 cycles after rising
        clr();
        din = 4'b0010;
        run(3);
        chk("t3_rising", 32'(rising), 32'h2);
        din = 4'b0000;
        run(8);
        chk("t3_no_early_fall", 32'(fc[1]), 32'd0);
        chk("t3_level_held", 32'(level), 32'h2);
        tick();
        chk("t3_falling", 32'(falling), 32'h2);
        chk("t3_level_low", 32'(level), 32'h0);
        run(12);

        // 4: all channels at once
        din = 4'b1111;
        run(3);
        chk("t4_rising_all", 32'(rising), 32'hf);
        chk("t4_any", 32'(any_edge), 32'h1);
        run(10);
        din = 4'b0000;
        run(3);
        chk("t4_falling_all", 32'(falling), 32'hf);
        chk("t4_level_low", 32'(level), 32'h0);
        run(10);

        // 5: masked pulse is dropped, not delayed
        clr();
        en  = 1'b0;
        din = 4'b0100;
        run(3);
        chk("t5_masked_rising", 32'(rising), 32'h0);
        chk("t5_level", 32'(level), 32'h4);
        chk("t5_any_masked", 32'(any_edge), 32'h0);
        en = 1'b1;
        run(12);
        chk("t5_no_stale", 32'(rc[2]), 32'd0);
        din = 4'b0000;
        run(3);
        chk("t5_falling", 32'(falling), 32'h4);
        run(10);

        // 6: reset mid-lockout, din held high across release
        din = 4'b1000;
        run(3);
        chk("t6_rising", 32'(rising), 32'h8);
        run(4);
        rst = 1'b1;
        tick();
        chk("t6_rst_rising", 32'(rising), 32'h0);
        chk("t6_rst_level", 32'(level), 32'h0);
        clr();
        rst = 1'b0;
        run(2);
        chk("t6_no_early", 32'(rc[3]), 32'd0);
        tick();
        chk("t6_rerise", 32'(rising), 32'h8);
        chk("t6_relevel", 32'(level), 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
